dm_arbiter: RTL and testbench

//  Shares the single-port word-addressed data memory between two requesters: port 0 is the pipeline MEM stage, port 1 is the debug/DMA loader.

---
 rtl/dm_arbiter.sv | 147 ++++++++++++++
 tb/tb_dm_arbiter.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dm_arbiter.sv
// Two-port round-robin arbiter in front of a single-port word memory.
// One transaction in flight; byte-lane steering on loads, read-modify-write for sub-word stores.
module dm_arbiter #(
  parameter int AW = 9,
  parameter int DW = 32
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          req_i,
  input  logic [1:0]          we_i,
  input  logic [1:0][AW-1:0]  addr_i,
  input  logic [1:0][2:0]     type_i,
  input  logic [1:0][DW-1:0]  wdata_i,
  output logic [1:0]          gnt_o,
  output logic [1:0]          done_o,
  output logic [1:0]          err_o,
  output logic [DW-1:0]       rdata_o,
  output logic [AW-3:0]       mem_addr_o,
  output logic                mem_we_o,
  output logic [DW-1:0]       mem_wdata_o,
  input  logic [DW-1:0]       mem_rdata_i
);

  localparam logic [2:0] T_W  = 3'd0;
  localparam logic [2:0] T_H  = 3'd1;
  localparam logic [2:0] T_HU = 3'd2;
  localparam logic [2:0] T_B  = 3'd3;
  localparam logic [2:0] T_BU = 3'd4;

  typedef enum logic [1:0] {IDLE, ACC, RMW_RD, RMW_WR} state_t;

  state_t          state_q, state_d;
  logic            rr_q;
  logic            port_q, we_q, err_q;
  logic [AW-1:0]   addr_q;
  logic [2:0]      type_q;
  logic [DW-1:0]   wdata_q, merge_q, rdata_q;
  logic [1:0]      done_q, errp_q;

  logic            sel, req_err, req_sub;
  logic [2:0]      req_t;
  logic [AW-1:0]   req_a;
  logic [7:0]      lane_b;
  logic [15:0]     lane_h;
  logic [DW-1:0]   ld_ext, merged;

  assign mem_addr_o = addr_q[AW-1:2];
  assign rdata_o    = rdata_q;
  assign done_o     = done_q;
  assign err_o      = errp_q;

  always_comb begin
    state_d     = state_q;
    gnt_o       = '0;
    mem_we_o    = 1'b0;
    mem_wdata_o = wdata_q;
    // Both requesting: take the favoured port; otherwise whichever is asking.
    sel         = (&req_i) ? rr_q : req_i[1];
    req_t       = type_i[sel];
    req_a       = addr_i[sel];
    req_err     = (req_t > T_BU) ||
                  (((req_t == T_H) || (req_t == T_HU)) && req_a[0]) ||
                  ((req_t == T_W) && (req_a[1:0] != 2'b00));
    req_sub     = we_i[sel] && !req_err && (req_t != T_W);

    lane_b = mem_rdata_i[{addr_q[1:0], 3'b000} +: 8];
    lane_h = mem_rdata_i[{addr_q[1], 4'b0000} +: 16];
    case (type_q)
      T_H:     ld_ext = {{16{lane_h[15]}}, lane_h};
      T_HU:    ld_ext = {16'h0000, lane_h};
      T_B:     ld_ext = {{24{lane_b[7]}}, lane_b};
      T_BU:    ld_ext = {24'h000000, lane_b};
      default: ld_ext = mem_rdata_i;
    endcase

    merged = merge_q;
    case (type_q)
      T_H, T_HU: merged[{addr_q[1], 4'b0000} +: 16]   = wdata_q[15:0];
      T_B, T_BU: merged[{addr_q[1:0], 3'b000} +: 8]   = wdata_q[7:0];
      default:   merged = merge_q;
    endcase

    case (state_q)
      IDLE: if ((|req_i) && !rst) begin
        gnt_o[sel] = 1'b1;
        state_d    = req_sub ? RMW_RD : ACC;
      end
      ACC: begin
        mem_we_o = we_q && !err_q;
        state_d  = IDLE;
      end
      RMW_RD: state_d = RMW_WR;
      RMW_WR: begin
        mem_we_o    = 1'b1;
        mem_wdata_o = merged;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
    // An aborted operation must never reach memory.
    if (rst) mem_we_o = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      rr_q    <= 1'b0;
      port_q  <= 1'b0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      type_q  <= '0;
      wdata_q <= '0;
      merge_q <= '0;
      rdata_q <= '0;
      done_q  <= '0;
      errp_q  <= '0;
    end else begin
      state_q <= state_d;
      done_q  <= '0;
      errp_q  <= '0;
      if (|gnt_o) begin
        rr_q    <= ~sel;
        port_q  <= sel;
        we_q    <= we_i[sel];
        addr_q  <= req_a;
        type_q  <= req_t;
        wdata_q <= wdata_i[sel];
        err_q   <= req_err;
      end
      case (state_q)
        ACC: begin
          rdata_q        <= (we_q || err_q) ? '0 : ld_ext;
          done_q[port_q] <= 1'b1;
          errp_q[port_q] <= err_q;
        end
        RMW_RD: merge_q <= mem_rdata_i;
        RMW_WR: begin
          rdata_q        <= '0;
          done_q[port_q] <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_arbiter.sv
// Bench for dm_arbiter: transaction-level model with a byte-addressed view of memory,
// directed literal cases plus a randomized two-port phase.
module tb_dm_arbiter;
  localparam int AW = 9;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]          req, we;
  logic [1:0][AW-1:0]  addr;
  logic [1:0][2:0]     typ;
  logic [1:0][31:0]    wd;
  logic [1:0]          gnt, done, err;
  logic [31:0]         rdata, mem_wdata, mem_rdata;
  logic [AW-3:0]       mem_addr;
  logic                mem_we;

  logic [31:0] mem     [128];
  logic [31:0] ref_mem [128];
  logic        pre_we;
  logic [6:0]  pre_addr;
  logic [31:0] pre_data;

  int checks = 0;
  int errors = 0;
  int rmode  = 0;   // 0 directed, 1 random, 2 draining

  dm_arbiter #(.AW(AW), .DW(32)) dut (
    .clk(clk), .rst(rst),
    .req_i(req), .we_i(we), .addr_i(addr), .type_i(typ), .wdata_i(wd),
    .gnt_o(gnt), .done_o(done), .err_o(err), .rdata_o(rdata),
    .mem_addr_o(mem_addr), .mem_we_o(mem_we), .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] <= mem_wdata;
    if (pre_we) mem[pre_addr] <= pre_data;
  end
  assign mem_rdata = mem[mem_addr];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  function automatic logic bad(input logic [AW-1:0] a, input logic [2:0] t);
    return (t > 3'd4) || ((t == 3'd1 || t == 3'd2) && a[0]) || (t == 3'd0 && a[1:0] != 2'b00);
  endfunction

  function automatic int nbytes(input logic [2:0] t);
    return (t == 3'd0) ? 4 : ((t <= 3'd2) ? 2 : 1);
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] w, input logic [AW-1:0] a, input logic [2:0] t);
    int n = nbytes(t);
    logic [31:0] v, m;
    if (n == 4) return w;
    v = w >> (8 * int'(a[1:0]));
    m = (n == 2) ? 32'h0000FFFF : 32'h000000FF;
    v = v & m;
    if ((t == 3'd1 || t == 3'd3) && v[8*n-1]) v = v | ~m;
    return v;
  endfunction

  function automatic logic [31:0] store_word(input logic [31:0] w, input logic [AW-1:0] a,
                                             input logic [2:0] t, input logic [31:0] d);
    int n = nbytes(t);
    int l = int'(a[1:0]);
    for (int i = 0; i < n; i++) w[8*(l+i) +: 8] = d[8*i +: 8];
    return w;
  endfunction

  // Reference model: one pending transaction, completing a fixed number of cycles after grant.
  int          cyc = 0;
  logic        pend = 1'b0;
  int          done_cyc, cw;
  logic        pport, pwe, perr, last = 1'b1, msel;
  logic [AW-1:0] pa;
  logic [2:0]  pt;
  logic [31:0] pd, exp_rd;
  logic [1:0]  ed, ee, eg;

  initial forever begin
    @(negedge clk);
    cyc++;
    if (rst) begin
      pend = 1'b0;
      last = 1'b1;
      chk("we_in_rst", 32'(mem_we), 32'd0);
      chk("gnt_in_rst", 32'(gnt), 32'd0);
    end else begin
      ed = 2'b00;
      ee = 2'b00;
      if (pend && cyc == done_cyc) begin
        ed[pport] = 1'b1;
        ee[pport] = perr;
        cw = int'(pa[AW-1:2]);
        if (pwe && !perr) ref_mem[cw] = store_word(ref_mem[cw], pa, pt, pd);
        exp_rd = (pwe || perr) ? 32'd0 : load_val(ref_mem[cw], pa, pt);
        chk("rdata", rdata, exp_rd);
        chk("mem_word", mem[cw], ref_mem[cw]);
        pend = 1'b0;
      end
      chk("done", 32'(done), 32'(ed));
      chk("err", 32'(err), 32'(ee));
      chk("mem_we", 32'(mem_we), 32'(pend && pwe && !perr && cyc == done_cyc - 1));
      if (pend && mem_we) chk("mem_addr", 32'(mem_addr), 32'(pa[AW-1:2]));
      if (!pend) begin
        if (req == 2'b11) begin msel = ~last; eg = msel ? 2'b10 : 2'b01; end
        else begin msel = req[1]; eg = req; end
        chk("gnt", 32'(gnt), 32'(eg));
        if (eg != 2'b00) begin
          pend  = 1'b1;
          pport = msel;
          pwe   = we[msel];
          pa    = addr[msel];
          pt    = typ[msel];
          pd    = wd[msel];
          perr  = bad(pa, pt);
          done_cyc = cyc + ((pwe && !perr && pt != 3'd0) ? 3 : 2);
          last  = msel;
        end
      end else begin
        chk("gnt_busy", 32'(gnt), 32'd0);
      end
    end
  end

  // Random requester for both ports.
  logic [1:0] gs;
  initial forever begin
    @(negedge clk);
    gs = gnt;
    @(posedge clk);
    #1;
    for (int p = 0; p < 2; p++) begin
      if (gs[p] && rmode != 0) req[p] = 1'b0;
      if (rmode == 1 && !req[p] && $urandom_range(0, 2) == 0) begin
        we[p]   = 1'($urandom_range(0, 1));
        addr[p] = AW'($urandom_range(0, 511));
        typ[p]  = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
        wd[p]   = $urandom;
        req[p]  = 1'b1;
      end
    end
  end

  task automatic poke(input int a, input logic [31:0] d);
    pre_addr = 7'(a);
    pre_data = d;
    pre_we   = 1'b1;
    ref_mem[a] = d;
    @(posedge clk); #1;
    pre_we = 1'b0;
  endtask

  // Issue one request on a port and wait for its completion; called in the drive phase.
  task automatic do_op(input int p, input logic w, input logic [AW-1:0] a, input logic [2:0] t,
                       input logic [31:0] d, output logic [31:0] rd, output logic er,
                       output int lat, output int wes);
    int n = 0;
    rd = 32'd0; er = 1'b0; lat = -1; wes = 0;
    we[p] = w; addr[p] = a; typ[p] = t; wd[p] = d; req[p] = 1'b1;
    forever begin
      @(negedge clk);
      if (gnt[p]) break;
      n++;
      if (n > 50) begin
        chk("grant_timeout", 32'd0, 32'd1);
        req[p] = 1'b0;
        @(posedge clk); #1;
        return;
      end
    end
    @(posedge clk); #1;
    req[p] = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (mem_we) wes++;
      if (done[p]) begin rd = rdata; er = err[p]; break; end
      if (lat > 20) begin chk("done_timeout", 32'd0, 32'd1); break; end
    end
    @(posedge clk); #1;
  endtask

  logic [31:0] rd;
  logic        er;
  int          lat, wes, nwe, ndone, n;
  logic [5:0]  seq;

  initial begin
    req = '0; we = '0; addr = '0; typ = '0; wd = '0;
    pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    @(posedge clk); #1;
    for (int i = 0; i < 128; i++) poke(i, $urandom);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_mem_addr", 32'(mem_addr), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_mem_we", 32'(mem_we), 32'd0);
    @(posedge clk); #1;

    do_op(0, 1'b1, 9'h010, 3'd0, 32'hDEADBEEF, rd, er, lat, wes);
    chk("t1_mem", mem[4], 32'hDEADBEEF);
    chk("t1_lat", 32'(lat), 32'd2);
    chk("t1_err", 32'(er), 32'd0);

    poke(4, 32'h11223344);
    do_op(1, 1'b1, 9'h012, 3'd3, 32'h000000AB, rd, er, lat, wes);
    chk("t2_mem", mem[4], 32'h11AB3344);
    chk("t2_lat", 32'(lat), 32'd3);
    do_op(1, 1'b0, 9'h012, 3'd3, 32'd0, rd, er, lat, wes);
    chk("t2_lb", rd, 32'hFFFFFFAB);
    do_op(1, 1'b0, 9'h012, 3'd4, 32'd0, rd, er, lat, wes);
    chk("t2_lbu", rd, 32'h000000AB);

    poke(5, 32'hCAFEF00D);
    do_op(0, 1'b1, 9'h016, 3'd1, 32'h00008001, rd, er, lat, wes);
    chk("t3_mem", mem[5], 32'h8001F00D);
    do_op(0, 1'b0, 9'h016, 3'd1, 32'd0, rd, er, lat, wes);
    chk("t3_lh", rd, 32'hFFFF8001);
    do_op(0, 1'b0, 9'h015, 3'd1, 32'd0, rd, er, lat, wes);
    chk("t3_mis_err", 32'(er), 32'd1);
    chk("t3_mis_rdata", rd, 32'd0);
    chk("t3_mem_kept", mem[5], 32'h8001F00D);

    do_op(1, 1'b1, 9'h020, 3'd7, 32'h12345678, rd, er, lat, wes);
    chk("t6_err", 32'(er), 32'd1);
    chk("t6_we", 32'(wes), 32'd0);
    chk("t6_lat", 32'(lat), 32'd2);

    // Both ports held high from reset: grants must alternate starting with port 0.
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    we = 2'b00; typ = '0; addr[0] = 9'h040; addr[1] = 9'h044; req = 2'b11;
    for (int k = 0; k < 6; k++) begin
      n = 0;
      forever begin
        @(negedge clk);
        if (gnt != 2'b00 || n > 10) break;
        n++;
      end
      seq[k] = gnt[1];
      chk("t4_grant_seen", 32'(gnt != 2'b00), 32'd1);
      @(posedge clk); #1;
      if (k == 5) req = 2'b00;
    end
    for (int k = 0; k < 6; k++) chk("t4_order", 32'(seq[k]), 32'(k % 2));
    repeat (4) @(posedge clk);
    #1;

    // Reset while the byte store sits in its read phase.
    poke(7, 32'h01020304);
    we[0] = 1'b1; addr[0] = 9'h01C; typ[0] = 3'd3; wd[0] = 32'h55; req[0] = 1'b1;
    n = 0;
    forever begin
      @(negedge clk);
      if (gnt[0] || n > 10) break;
      n++;
    end
    chk("t5_grant", 32'(gnt[0]), 32'd1);
    @(posedge clk); #1;
    req[0] = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    nwe = 0; ndone = 0;
    repeat (6) begin
      @(negedge clk);
      if (mem_we) nwe++;
      if (done != 2'b00) ndone++;
    end
    @(posedge clk); #1;
    chk("t5_no_we", 32'(nwe), 32'd0);
    chk("t5_no_done", 32'(ndone), 32'd0);
    chk("t5_mem_kept", mem[7], 32'h01020304);
    do_op(0, 1'b0, 9'h01C, 3'd0, 32'd0, rd, er, lat, wes);
    chk("t5_idle_lat", 32'(lat), 32'd2);
    chk("t5_load", rd, 32'h01020304);

    rmode = 1;
    repeat (2500) @(posedge clk);
    rmode = 2;
    n = 0;
    while (req != 2'b00 && n < 100) begin @(posedge clk); n++; end
    chk("drain", 32'(req), 32'd0);
    repeat (6) @(posedge clk);
    #1;
    rmode = 0;
    for (int i = 0; i < 128; i++) chk("final_mem", mem[i], ref_mem[i]);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
